// File: rtl/mac_check_arbiter_if.sv
// ---------------------------------------------------------------------------
// mac_check_arbiter_if
// Bundle between the per-lane frame builders / MAC checker and the shared
// checker arbiter.
//   i_req, i_frame_done     : per-source request level and frame-written pulse
//   o_gnt                   : one-hot grant of the shared frame buffer
//   o_check_start           : one-cycle launch pulse to the checker
//   i_check_done/i_check_err: checker completion pulse and error flags
//   i_clr_cnt               : synchronous statistics clear
//   o_busy                  : arbiter not idle
//   o_result_*/o_timeout    : per-frame result strobe, source tag, flags
//   o_frame_cnt/o_err_cnt   : saturating statistics
// Modport slave is the arbiter side, master the environment side.
// ---------------------------------------------------------------------------
interface mac_check_arbiter_if #(
   parameter int N_REQ     = 4,
   parameter int SRC_W     = $clog2(N_REQ),
   parameter int CNT_WIDTH = 32
);
   logic [N_REQ-1:0]     i_req;
   logic [N_REQ-1:0]     o_gnt;
   logic [N_REQ-1:0]     i_frame_done;
   logic                 o_check_start;
   logic                 i_check_done;
   logic [3:0]           i_check_err;
   logic                 i_clr_cnt;
   logic                 o_busy;
   logic                 o_result_valid;
   logic [SRC_W-1:0]     o_result_src;
   logic [3:0]           o_result_err;
   logic                 o_timeout;
   logic [CNT_WIDTH-1:0] o_frame_cnt;
   logic [CNT_WIDTH-1:0] o_err_cnt;

   modport slave (
      input  i_req, i_frame_done, i_check_done, i_check_err, i_clr_cnt,
      output o_gnt, o_check_start, o_busy, o_result_valid, o_result_src,
             o_result_err, o_timeout, o_frame_cnt, o_err_cnt
   );

   modport master (
      output i_req, i_frame_done, i_check_done, i_check_err, i_clr_cnt,
      input  o_gnt, o_check_start, o_busy, o_result_valid, o_result_src,
             o_result_err, o_timeout, o_frame_cnt, o_err_cnt
   );
endinterface

// File: rtl/mac_check_arbiter.sv
// ---------------------------------------------------------------------------
// mac_check_arbiter
// Round-robin owner of one shared MAC frame checker. Grants one source the
// frame buffer, launches the checker when that source's frame is written,
// waits for done or a timeout and returns a source-tagged result while
// keeping saturating frame/error counters.
//   clk     : rising-edge clock
//   i_rst_n : asynchronous active-low reset (in-flight check is dropped)
//   bus     : mac_check_arbiter_if.slave, see the interface for signals
// ---------------------------------------------------------------------------
module mac_check_arbiter #(
   parameter int N_REQ         = 4,
   parameter int SRC_W         = $clog2(N_REQ),
   parameter int CHECK_TIMEOUT = 64,
   parameter int CNT_WIDTH     = 32
) (
   input  logic               clk,
   input  logic               i_rst_n,
   mac_check_arbiter_if.slave bus
);
   localparam int              TO_W    = $clog2(CHECK_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(CHECK_TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_START, S_WAIT} state_t;

   state_t           state, state_nxt;
   logic [SRC_W-1:0] cur, cur_nxt;
   logic [SRC_W-1:0] last, last_nxt;
   logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
   logic [N_REQ-1:0] gnt_nxt;
   logic             start_nxt;
   logic             res_vld_nxt;
   logic             res_to_nxt;
   logic [3:0]       res_err_nxt;

   logic             rr_hit;
   logic [SRC_W-1:0] rr_idx;
   logic [SRC_W-1:0] rr_probe;

   // First requesting source at or after last+1, wrapping.
   always_comb begin
      rr_hit   = 1'b0;
      rr_idx   = '0;
      rr_probe = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         rr_probe = SRC_W'((int'(last) + i) % N_REQ);
         if (!rr_hit && bus.i_req[rr_probe]) begin
            rr_hit = 1'b1;
            rr_idx = rr_probe;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      cur_nxt     = cur;
      last_nxt    = last;
      to_cnt_nxt  = to_cnt;
      gnt_nxt     = '0;
      start_nxt   = 1'b0;
      res_vld_nxt = 1'b0;
      res_to_nxt  = 1'b0;
      res_err_nxt = '0;
      unique case (state)
         S_IDLE: begin
            if (rr_hit) begin
               gnt_nxt   = N_REQ'(1) << rr_idx;
               cur_nxt   = rr_idx;
               state_nxt = S_GRANT;
            end
         end
         S_GRANT: begin
            // Done beats a simultaneous request drop.
            if (bus.i_frame_done[cur]) begin
               start_nxt = 1'b1;
               state_nxt = S_START;
            end else if (!bus.i_req[cur]) begin
               last_nxt  = cur;
               state_nxt = S_IDLE;
            end else begin
               gnt_nxt = N_REQ'(1) << cur;
            end
         end
         S_START: begin
            to_cnt_nxt = '0;
            state_nxt  = S_WAIT;
         end
         S_WAIT: begin
            to_cnt_nxt = to_cnt + 1'b1;
            // Done on the last allowed cycle still counts as done.
            if (bus.i_check_done) begin
               res_vld_nxt = 1'b1;
               res_err_nxt = bus.i_check_err;
               last_nxt    = cur;
               state_nxt   = S_IDLE;
            end else if (to_cnt == TO_LAST) begin
               res_vld_nxt = 1'b1;
               res_to_nxt  = 1'b1;
               res_err_nxt = 4'hF;
               last_nxt    = cur;
               state_nxt   = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state              <= S_IDLE;
         cur                <= '0;
         last               <= SRC_W'(N_REQ - 1);
         to_cnt             <= '0;
         bus.o_gnt          <= '0;
         bus.o_check_start  <= 1'b0;
         bus.o_result_valid <= 1'b0;
         bus.o_result_src   <= '0;
         bus.o_result_err   <= '0;
         bus.o_timeout      <= 1'b0;
      end else begin
         state              <= state_nxt;
         cur                <= cur_nxt;
         last               <= last_nxt;
         to_cnt             <= to_cnt_nxt;
         bus.o_gnt          <= gnt_nxt;
         bus.o_check_start  <= start_nxt;
         bus.o_result_valid <= res_vld_nxt;
         bus.o_timeout      <= res_to_nxt;
         if (res_vld_nxt) begin
            bus.o_result_src <= cur;
            bus.o_result_err <= res_err_nxt;
         end
      end
   end

   // Timeout forces all flags set, so |err alone covers the error count.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bus.o_frame_cnt <= '0;
         bus.o_err_cnt   <= '0;
      end else if (bus.i_clr_cnt) begin
         bus.o_frame_cnt <= '0;
         bus.o_err_cnt   <= '0;
      end else if (res_vld_nxt) begin
         if (bus.o_frame_cnt != '1)
            bus.o_frame_cnt <= bus.o_frame_cnt + 1'b1;
         if ((|res_err_nxt) && (bus.o_err_cnt != '1))
            bus.o_err_cnt <= bus.o_err_cnt + 1'b1;
      end
   end

   assign bus.o_busy = (state != S_IDLE);

endmodule
